// File: rtl/ulbf_master_tx.sv
// ulbf_master_tx: RAM playback to AXI4-Stream with a credit-limited skid FIFO.
// Build option ULBF_TX_HOST_PIPE_EN adds four register stages on host port B.
module ulbf_master_tx #(
    parameter int TDATA_WIDTH       = 64,
    parameter int TKEEP_WIDTH       = 8,
    parameter int URAM_DEPTH        = 8192,
    parameter int URAM_READ_LATENCY = 4,
    parameter int FIFO_DEPTH        = 8
) (
    input  logic                   m_axis_clk,
    input  logic                   master_rst_n,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic [TDATA_WIDTH-1:0] m_axis_tdata,
    output logic [TKEEP_WIDTH-1:0] m_axis_tkeep,
    input  logic                   start,
    input  logic [11:0]            niter,
    input  logic [15:0]            block_len,
    output logic                   txdone,
    output logic [3:0]             current_state_wire,
    output logic [15:0]            txram_counter_wire,
    input  logic [7:0]             web,
    input  logic                   enb,
    input  logic [15:0]            addrb,
    input  logic [63:0]            dinb,
    output logic [63:0]            doutb
);
    localparam int L  = URAM_READ_LATENCY;
    localparam int AW = $clog2(URAM_DEPTH);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int CW = FW + 1;
    localparam logic [CW-1:0] FDEP = CW'(FIFO_DEPTH);

    typedef enum logic [3:0] {
        IDLE  = 4'h1,
        FETCH = 4'h2,
        DRAIN = 4'h4,
        DONE  = 4'h8
    } state_t;

    logic rst_meta, rst_n_s;

    always_ff @(posedge m_axis_clk or negedge master_rst_n) begin
        if (!master_rst_n) begin
            rst_meta <= 1'b0;
            rst_n_s  <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_n_s  <= rst_meta;
        end
    end

    state_t state;
    logic [11:0] niter_q, blk;
    logic [15:0] blen_q, addr, tx_cnt;
    logic txdone_q, rd_en_q, rd_last_q;
    logic [AW-1:0] rd_addr_q;
    logic [L-1:0] v_pipe;
    logic l_pipe [L];
    logic [TDATA_WIDTH-1:0] d_pipe [L];
    logic [CW-1:0] inflight, fifo_cnt;
    logic [FW-1:0] wp, rp;
    logic [TDATA_WIDTH-1:0] f_data [FIFO_DEPTH];
    logic f_last [FIFO_DEPTH];
    logic [TDATA_WIDTH-1:0] ram [URAM_DEPTH];
    logic [63:0] b_pipe [L];
    logic issue, push, pop, last_word, last_blk, launch, idle_like;

    assign push      = v_pipe[L-1];
    assign pop       = (fifo_cnt != '0) && m_axis_tready;
    assign issue     = (state == FETCH) && ((inflight + fifo_cnt) < FDEP);
    assign last_word = (addr == blen_q - 16'd1);
    assign last_blk  = (niter_q != 12'd0) && (blk == niter_q - 12'd1);
    assign launch    = start && (block_len != 16'd0);
    assign idle_like = (state == IDLE) || (state == DONE);

    always_ff @(posedge m_axis_clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state     <= IDLE;
            niter_q   <= '0;
            blen_q    <= '0;
            blk       <= '0;
            addr      <= '0;
            txdone_q  <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_last_q <= 1'b0;
        end else begin
            rd_en_q <= issue;
            if (issue) begin
                rd_addr_q <= AW'({1'b0, addr} % 17'(URAM_DEPTH));
                rd_last_q <= last_word;
            end
            unique case (state)
                IDLE, DONE: if (launch) begin
                    state    <= FETCH;
                    niter_q  <= niter;
                    blen_q   <= block_len;
                    blk      <= '0;
                    addr     <= '0;
                    txdone_q <= 1'b0;
                end
                FETCH: if (issue) begin
                    if (last_word) begin
                        addr <= '0;
                        blk  <= blk + 12'd1;
                        if (last_blk) state <= DRAIN;
                    end else begin
                        addr <= addr + 16'd1;
                    end
                end
                DRAIN: if (inflight == '0 && fifo_cnt == '0) begin
                    state    <= DONE;
                    txdone_q <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // inflight + fifo_cnt is the FIFO credit: it never exceeds FIFO_DEPTH
    always_ff @(posedge m_axis_clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            inflight <= '0;
            fifo_cnt <= '0;
            wp       <= '0;
            rp       <= '0;
            v_pipe   <= '0;
            tx_cnt   <= '0;
        end else begin
            inflight  <= inflight + CW'(issue) - CW'(push);
            fifo_cnt  <= fifo_cnt + CW'(push) - CW'(pop);
            v_pipe[0] <= rd_en_q;
            for (int k = 1; k < L; k++) v_pipe[k] <= v_pipe[k-1];
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            if (launch && idle_like) tx_cnt <= '0;
            else if (pop) tx_cnt <= tx_cnt + 16'd1;
        end
    end

    logic [7:0]  hb_we;
    logic        hb_en;
    logic [15:0] hb_addr;
    logic [63:0] hb_din;
    logic [AW-1:0] b_addr;

`ifdef ULBF_TX_HOST_PIPE_EN
    logic [7:0]  we_p [4];
    logic [3:0]  en_p;
    logic [15:0] addr_p [4];
    logic [63:0] din_p [4];

    always_ff @(posedge m_axis_clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            en_p <= '0;
            for (int k = 0; k < 4; k++) begin
                we_p[k]   <= '0;
                addr_p[k] <= '0;
                din_p[k]  <= '0;
            end
        end else begin
            en_p      <= {en_p[2:0], enb};
            we_p[0]   <= web;
            addr_p[0] <= addrb;
            din_p[0]  <= dinb;
            for (int k = 1; k < 4; k++) begin
                we_p[k]   <= we_p[k-1];
                addr_p[k] <= addr_p[k-1];
                din_p[k]  <= din_p[k-1];
            end
        end
    end

    assign hb_we   = we_p[3];
    assign hb_en   = en_p[3];
    assign hb_addr = addr_p[3];
    assign hb_din  = din_p[3];
`else
    assign hb_we   = web;
    assign hb_en   = enb;
    assign hb_addr = addrb;
    assign hb_din  = dinb;
`endif

    assign b_addr = AW'({1'b0, hb_addr} % 17'(URAM_DEPTH));

    always_ff @(posedge m_axis_clk) begin
        d_pipe[0] <= ram[rd_addr_q];
        l_pipe[0] <= rd_last_q;
        for (int k = 1; k < L; k++) begin
            d_pipe[k] <= d_pipe[k-1];
            l_pipe[k] <= l_pipe[k-1];
        end
        if (push) begin
            f_data[wp] <= d_pipe[L-1];
            f_last[wp] <= l_pipe[L-1];
        end
        if (hb_en) begin
            for (int i = 0; i < 8; i++)
                if (hb_we[i]) ram[b_addr][i*8 +: 8] <= hb_din[i*8 +: 8];
        end
    end

    // doutb only follows pure reads and holds the last read word
    always_ff @(posedge m_axis_clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            for (int k = 0; k < L; k++) b_pipe[k] <= '0;
        end else begin
            if (hb_en && hb_we == 8'h00) b_pipe[0] <= ram[b_addr];
            for (int k = 1; k < L; k++) b_pipe[k] <= b_pipe[k-1];
        end
    end

    assign m_axis_tvalid      = (fifo_cnt != '0);
    assign m_axis_tdata       = m_axis_tvalid ? f_data[rp] : '0;
    assign m_axis_tlast       = m_axis_tvalid && f_last[rp];
    assign m_axis_tkeep       = {TKEEP_WIDTH{m_axis_tvalid}};
    assign txdone             = txdone_q;
    assign current_state_wire = state;
    assign txram_counter_wire = tx_cnt;
    assign doutb              = b_pipe[L-1];

endmodule

// File: tb/tb_ulbf_master_tx.sv
// tb_ulbf_master_tx: directed playback, backpressure, reset and host-port
// vectors for ulbf_master_tx with hand-computed expectations.
module tb_ulbf_master_tx;
    localparam int L  = 4;
    localparam int FD = 8;
`ifdef ULBF_TX_HOST_PIPE_EN
    localparam int HL = L + 4;
`else
    localparam int HL = L;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tvalid, tready, tlast;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        start;
    logic [11:0] niter;
    logic [15:0] block_len;
    logic        txdone;
    logic [3:0]  state;
    logic [15:0] cnt;
    logic [7:0]  web;
    logic        enb;
    logic [15:0] addrb;
    logic [63:0] dinb, doutb;

    int total = 0;
    int bad   = 0;

    ulbf_master_tx dut (
        .m_axis_clk         (clk),
        .master_rst_n       (rst_n),
        .m_axis_tvalid      (tvalid),
        .m_axis_tready      (tready),
        .m_axis_tlast       (tlast),
        .m_axis_tdata       (tdata),
        .m_axis_tkeep       (tkeep),
        .start              (start),
        .niter              (niter),
        .block_len          (block_len),
        .txdone             (txdone),
        .current_state_wire (state),
        .txram_counter_wire (cnt),
        .web                (web),
        .enb                (enb),
        .addrb              (addrb),
        .dinb               (dinb),
        .doutb              (doutb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic hwrite(input logic [15:0] a, input logic [63:0] d);
        addrb = a;
        dinb  = d;
        web   = 8'hFF;
        enb   = 1'b1;
        step();
        enb   = 1'b0;
        web   = 8'h00;
    endtask

    // mode 0: tready=1, 1: toggling, 2: held low for 50 cycles
    task automatic run(input int n_it, input int bl, input int mode);
        logic [63:0] bd [64];
        logic        bt [64];
        int nb = 0, first = -1, last_i = 0, unstable = 0, e = 0;
        logic pv = 1'b0, pl = 1'b0, done = 1'b0;
        logic [63:0] pd = '0;
        niter     = 12'(n_it);
        block_len = 16'(bl);
        start     = 1'b1;
        step();
        start     = 1'b0;
        niter     = 12'd0;
        block_len = 16'd7;
        chk("txdone_clr", {63'd0, txdone}, 64'd0);
        for (int i = 0; i < 400 && !done; i++) begin
            case (mode)
                1:       tready = (i[0] == 1'b0);
                2:       tready = (i >= 50);
                default: tready = 1'b1;
            endcase
            start = (mode == 1 && i == 2);
            #0;
            if (mode == 2 && i == 49) begin
                chk("fifo_full", 64'(dut.fifo_cnt), 64'(FD));
                chk("hold_valid", {63'd0, tvalid}, 64'd1);
            end
            if (tvalid && first < 0) begin
                first = i;
                chk("tkeep", {56'd0, tkeep}, 64'hFF);
            end
            if (pv && (tdata !== pd || tlast !== pl)) unstable++;
            pv = tvalid && !tready;
            pd = tdata;
            pl = tlast;
            if (tvalid && tready && nb < 64) begin
                bd[nb] = tdata;
                bt[nb] = tlast;
                nb++;
                last_i = i;
            end
            if (txdone) done = 1'b1;
            step();
        end
        start  = 1'b0;
        tready = 1'b1;
        chk("done", {63'd0, done}, 64'd1);
        chk("nbeats", 64'(nb), 64'(n_it * bl));
        for (int k = 0; k < nb; k++) begin
            if (bd[k] !== 64'((k % bl) + 1)) e++;
            if (bt[k] !== ((k % bl) == bl - 1)) e++;
        end
        chk("sequence", 64'(e), 64'd0);
        chk("counter", {48'd0, cnt}, 64'(n_it * bl));
        chk("state_done", {60'd0, state}, 64'h8);
        chk("stable", 64'(unstable), 64'd0);
        if (mode == 0) begin
            chk("latency", 64'(first), 64'(L + 2));
            chk("no_bubble", 64'(last_i - first), 64'(nb - 1));
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        tready    = 1'b1;
        start     = 1'b0;
        niter     = '0;
        block_len = '0;
        web       = '0;
        enb       = 1'b0;
        addrb     = '0;
        dinb      = '0;
        step();
        step();
        chk("rst_tvalid", {63'd0, tvalid}, 64'd0);
        chk("rst_state", {60'd0, state}, 64'h1);
        chk("rst_txdone", {63'd0, txdone}, 64'd0);
        chk("rst_cnt", {48'd0, cnt}, 64'd0);
        chk("rst_tdata", tdata, 64'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) step();

        for (int k = 0; k < 4; k++) hwrite(16'(k), 64'(k + 1));
        for (int k = 0; k < 8; k++) step();

        addrb = 16'd2;
        enb   = 1'b1;
        step();
        enb   = 1'b0;
        for (int k = 0; k < HL - 2; k++) step();
        chk("host_early", doutb, 64'd0);
        step();
        chk("host_rd", doutb, 64'd3);

        block_len = 16'd0;
        niter     = 12'd2;
        start     = 1'b1;
        step();
        start     = 1'b0;
        step();
        step();
        chk("zero_len", {60'd0, state}, 64'h1);
        chk("zero_len_v", {63'd0, tvalid}, 64'd0);

        run(2, 4, 0);
        run(2, 4, 1);
        run(2, 4, 2);
        run(3, 1, 0);

        niter     = 12'd2;
        block_len = 16'd4;
        start     = 1'b1;
        step();
        start     = 1'b0;
        begin
            logic hit = 1'b0;
            for (int i = 0; i < 50 && !hit; i++) begin
                if (tvalid && tdata == 64'd2) hit = 1'b1;
                else step();
            end
            chk("beat2_seen", {63'd0, hit}, 64'd1);
        end
        rst_n = 1'b0;
        #1;
        chk("mid_tvalid", {63'd0, tvalid}, 64'd0);
        chk("mid_state", {60'd0, state}, 64'h1);
        chk("mid_txdone", {63'd0, txdone}, 64'd0);
        chk("mid_tdata", tdata, 64'd0);
        chk("mid_doutb", doutb, 64'd0);
        step();
        step();
        chk("mid_quiet", {63'd0, tvalid}, 64'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) step();
        run(2, 4, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
